// File: rtl/regwrite_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// regwrite_arbiter_pkg
// Shared definitions for the register-file writeback arbiter:
//   DATA_W / ADDR_W : default data and register-index widths
//   req_id_e        : requester identity (ALU or load unit), also used as the
//                     round-robin pointer encoding
//   ZERO_REG        : index of the hard-wired zero register
//   rr_pick         : round-robin choice when both requesters contend
// -----------------------------------------------------------------------------
package regwrite_arbiter_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    typedef enum logic {
        REQ_ALU = 1'b0,
        REQ_MEM = 1'b1
    } req_id_e;

    localparam logic [ADDR_W-1:0] ZERO_REG = 5'd0;

    // Under contention the requester that did not win last time is served.
    function automatic req_id_e rr_pick(input req_id_e last_grant);
        req_id_e pick;
        case (last_grant)
            REQ_ALU: pick = REQ_MEM;
            REQ_MEM: pick = REQ_ALU;
            default: pick = REQ_ALU;
        endcase
        return pick;
    endfunction

endpackage

// File: rtl/regwrite_arbiter_rr_arbiter2.sv
// -----------------------------------------------------------------------------
// rr_arbiter2
// Two-way round-robin grant logic with its pointer register.
//   clock       : rising-edge clock
//   reset       : asynchronous active-low reset
//   i_req_alu   : ALU request valid
//   i_req_mem   : load request valid
//   i_block     : suppress all grants this cycle (stall or flush)
//   o_gnt_alu   : ALU granted this cycle (combinational)
//   o_gnt_mem   : load granted this cycle (combinational)
//   o_last      : requester granted most recently (resets to REQ_MEM so the
//                 first contention goes to the ALU)
// -----------------------------------------------------------------------------
module rr_arbiter2
    import regwrite_arbiter_pkg::*;
(
    input  logic    clock,
    input  logic    reset,
    input  logic    i_req_alu,
    input  logic    i_req_mem,
    input  logic    i_block,
    output logic    o_gnt_alu,
    output logic    o_gnt_mem,
    output req_id_e o_last
);

    req_id_e r_last;
    req_id_e w_pick;

    assign w_pick = rr_pick(r_last);

    // Grant decision; reset is included so no grant is visible while it is held.
    always_comb begin
        o_gnt_alu = 1'b0;
        o_gnt_mem = 1'b0;
        if (!reset || i_block) begin
            o_gnt_alu = 1'b0;
            o_gnt_mem = 1'b0;
        end else begin
            case ({i_req_alu, i_req_mem})
                2'b10:   o_gnt_alu = 1'b1;
                2'b01:   o_gnt_mem = 1'b1;
                2'b11: begin
                    o_gnt_alu = (w_pick == REQ_ALU);
                    o_gnt_mem = (w_pick == REQ_MEM);
                end
                default: begin
                    o_gnt_alu = 1'b0;
                    o_gnt_mem = 1'b0;
                end
            endcase
        end
    end

    // Pointer register: follows the granted requester, holds otherwise.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_last <= REQ_MEM;
        end else if (o_gnt_alu) begin
            r_last <= REQ_ALU;
        end else if (o_gnt_mem) begin
            r_last <= REQ_MEM;
        end else begin
            r_last <= r_last;
        end
    end

    assign o_last = r_last;

endmodule

// File: rtl/regwrite_arbiter.sv
// -----------------------------------------------------------------------------
// regwrite_arbiter
// Shares one register-file write port between the ALU and the load unit.
// Valid/ready handshake per requester; accepted writes appear on the
// registered write port one cycle later. Writes to x0 complete the handshake
// but never assert the write enable.
//   clock, reset                 : clock, asynchronous active-low reset
//   aluValid/aluAddr/aluData     : ALU writeback request
//   aluReady                     : ALU request accepted this cycle
//   memValid/memAddr/memData     : load writeback request
//   memReady                     : load request accepted this cycle
//   stall                        : freeze, no grants
//   flush                        : discard the staged write, no grants
//   RegWriteControl/Addr/DataIn  : registered register-file write port
//   lastGrant                    : round-robin pointer (0 = ALU, 1 = load)
// -----------------------------------------------------------------------------
module regwrite_arbiter
    import regwrite_arbiter_pkg::*;
#(
    parameter int dataW = DATA_W,
    parameter int addrW = ADDR_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             aluValid,
    input  logic [addrW-1:0] aluAddr,
    input  logic [dataW-1:0] aluData,
    output logic             aluReady,
    input  logic             memValid,
    input  logic [addrW-1:0] memAddr,
    input  logic [dataW-1:0] memData,
    output logic             memReady,
    input  logic             stall,
    input  logic             flush,
    output logic             RegWriteControl,
    output logic [addrW-1:0] RegWriteAddr,
    output logic [dataW-1:0] RegDataIn,
    output logic             lastGrant
);

    logic             w_gnt_alu;
    logic             w_gnt_mem;
    logic             w_accept;
    logic [addrW-1:0] w_sel_addr;
    logic [dataW-1:0] w_sel_data;
    req_id_e          w_last;

    logic             r_we;
    logic [addrW-1:0] r_addr;
    logic [dataW-1:0] r_data;

    rr_arbiter2 u_rr_arbiter2 (
        .clock     (clock),
        .reset     (reset),
        .i_req_alu (aluValid),
        .i_req_mem (memValid),
        .i_block   (stall | flush),
        .o_gnt_alu (w_gnt_alu),
        .o_gnt_mem (w_gnt_mem),
        .o_last    (w_last)
    );

    assign aluReady  = w_gnt_alu;
    assign memReady  = w_gnt_mem;
    assign lastGrant = (w_last == REQ_MEM);
    assign w_accept  = w_gnt_alu | w_gnt_mem;

    // Select the write payload of whichever requester holds the grant.
    always_comb begin
        w_sel_addr = aluAddr;
        w_sel_data = aluData;
        if (w_gnt_mem) begin
            w_sel_addr = memAddr;
            w_sel_data = memData;
        end else begin
            w_sel_addr = aluAddr;
            w_sel_data = aluData;
        end
    end

    // Output stage: enable pulses for one cycle per accepted non-x0 write;
    // address and data hold between acceptances.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_we   <= 1'b0;
            r_addr <= {addrW{1'b0}};
            r_data <= {dataW{1'b0}};
        end else if (flush) begin
            r_we   <= 1'b0;
            r_addr <= r_addr;
            r_data <= r_data;
        end else if (w_accept) begin
            r_we   <= (w_sel_addr != {addrW{1'b0}});
            r_addr <= w_sel_addr;
            r_data <= w_sel_data;
        end else begin
            r_we   <= 1'b0;
            r_addr <= r_addr;
            r_data <= r_data;
        end
    end

    assign RegWriteControl = r_we;
    assign RegWriteAddr    = r_addr;
    assign RegDataIn       = r_data;

endmodule

// File: tb/tb_regwrite_arbiter.sv
// -----------------------------------------------------------------------------
// tb_regwrite_arbiter
// Directed bench for regwrite_arbiter with a small register-file model fed by
// the write port. Inputs change 1 time unit after a rising edge; combinational
// readies are sampled 1 unit later, registered outputs 1 unit after the edge.
// -----------------------------------------------------------------------------
module tb_regwrite_arbiter;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clock;
    logic          reset;
    logic          aluValid;
    logic [AW-1:0] aluAddr;
    logic [DW-1:0] aluData;
    logic          aluReady;
    logic          memValid;
    logic [AW-1:0] memAddr;
    logic [DW-1:0] memData;
    logic          memReady;
    logic          stall;
    logic          flush;
    logic          RegWriteControl;
    logic [AW-1:0] RegWriteAddr;
    logic [DW-1:0] RegDataIn;
    logic          lastGrant;

    logic [DW-1:0] rf [0:31];

    int n_checks;
    int n_errors;

    regwrite_arbiter #(.dataW(DW), .addrW(AW)) dut (
        .clock           (clock),
        .reset           (reset),
        .aluValid        (aluValid),
        .aluAddr         (aluAddr),
        .aluData         (aluData),
        .aluReady        (aluReady),
        .memValid        (memValid),
        .memAddr         (memAddr),
        .memData         (memData),
        .memReady        (memReady),
        .stall           (stall),
        .flush           (flush),
        .RegWriteControl (RegWriteControl),
        .RegWriteAddr    (RegWriteAddr),
        .RegDataIn       (RegDataIn),
        .lastGrant       (lastGrant)
    );

    // Clock generation.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Register file model; x0 is hard-wired to zero.
    always @(posedge clock) begin
        if (RegWriteControl && RegWriteAddr != 5'd0) rf[RegWriteAddr] <= RegDataIn;
    end

    task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        aluValid = 1'b0; aluAddr = 5'd0; aluData = 32'd0;
        memValid = 1'b0; memAddr = 5'd0; memData = 32'd0;
        stall = 1'b0; flush = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step();
        step();
        #2 reset = 1'b1;
        step();
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        for (int i = 0; i < 32; i++) rf[i] = 32'd0;
        idle_inputs();
        reset = 1'b0;

        // Reset state, with a request held to show readiness is masked.
        step();
        aluValid = 1'b1; aluAddr = 5'd9; aluData = 32'd5;
        #1;
        check_value("rst_we", 64'(RegWriteControl), 64'd0);
        check_value("rst_addr", 64'(RegWriteAddr), 64'd0);
        check_value("rst_data", 64'(RegDataIn), 64'd0);
        check_value("rst_last", 64'(lastGrant), 64'd1);
        check_value("rst_aluready", 64'(aluReady), 64'd0);
        idle_inputs();
        #2 reset = 1'b1;
        step();

        // ALU alone: x1 <- 897.
        aluValid = 1'b1; aluAddr = 5'd1; aluData = 32'd897;
        #1;
        check_value("alu_ready", 64'(aluReady), 64'd1);
        check_value("alu_memready", 64'(memReady), 64'd0);
        step();
        check_value("alu_we", 64'(RegWriteControl), 64'd1);
        check_value("alu_addr", 64'(RegWriteAddr), 64'd1);
        check_value("alu_data", 64'(RegDataIn), 64'd897);
        check_value("alu_last", 64'(lastGrant), 64'd0);
        idle_inputs();
        step();
        check_value("alu_we_drop", 64'(RegWriteControl), 64'd0);
        check_value("alu_addr_hold", 64'(RegWriteAddr), 64'd1);
        check_value("rf_x1", 64'(rf[1]), 64'd897);

        // Contention after reset: ALU first, then load.
        do_reset();
        aluValid = 1'b1; aluAddr = 5'd2; aluData = 32'd666;
        memValid = 1'b1; memAddr = 5'd3; memData = 32'd65;
        #1;
        check_value("cont_aluready", 64'(aluReady), 64'd1);
        check_value("cont_memready0", 64'(memReady), 64'd0);
        step();
        check_value("cont_addr1", 64'(RegWriteAddr), 64'd2);
        check_value("cont_data1", 64'(RegDataIn), 64'd666);
        check_value("cont_last1", 64'(lastGrant), 64'd0);
        aluValid = 1'b0;
        #1;
        check_value("cont_memready1", 64'(memReady), 64'd1);
        step();
        check_value("cont_we2", 64'(RegWriteControl), 64'd1);
        check_value("cont_addr2", 64'(RegWriteAddr), 64'd3);
        check_value("cont_data2", 64'(RegDataIn), 64'd65);
        check_value("cont_last2", 64'(lastGrant), 64'd1);
        idle_inputs();
        step();
        check_value("rf_x2", 64'(rf[2]), 64'd666);
        check_value("rf_x3", 64'(rf[3]), 64'd65);

        // Back-to-back contention: grants alternate ALU, load, ALU, load.
        aluValid = 1'b1; aluAddr = 5'd10; aluData = 32'd100;
        memValid = 1'b1; memAddr = 5'd11; memData = 32'd200;
        for (int k = 0; k < 4; k++) begin
            #1;
            check_value("b2b_aluready", 64'(aluReady), ((k % 2) == 0) ? 64'd1 : 64'd0);
            check_value("b2b_memready", 64'(memReady), ((k % 2) == 1) ? 64'd1 : 64'd0);
            step();
            check_value("b2b_addr", 64'(RegWriteAddr), ((k % 2) == 0) ? 64'd10 : 64'd11);
        end
        idle_inputs();
        step();

        // Load to x0: handshake completes, no write enable.
        memValid = 1'b1; memAddr = 5'd0; memData = 32'd123;
        #1;
        check_value("x0_memready", 64'(memReady), 64'd1);
        step();
        check_value("x0_we", 64'(RegWriteControl), 64'd0);
        check_value("x0_addr", 64'(RegWriteAddr), 64'd0);
        check_value("x0_data", 64'(RegDataIn), 64'd123);
        check_value("x0_last", 64'(lastGrant), 64'd1);
        idle_inputs();
        step();
        check_value("rf_x0", 64'(rf[0]), 64'd0);

        // Stall for three cycles with the ALU waiting.
        aluValid = 1'b1; aluAddr = 5'd4; aluData = 32'h55;
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            check_value("stall_aluready", 64'(aluReady), 64'd0);
            step();
            check_value("stall_we", 64'(RegWriteControl), 64'd0);
        end
        stall = 1'b0;
        #1;
        check_value("unstall_aluready", 64'(aluReady), 64'd1);
        step();
        check_value("unstall_we", 64'(RegWriteControl), 64'd1);
        check_value("unstall_addr", 64'(RegWriteAddr), 64'd4);
        check_value("unstall_last", 64'(lastGrant), 64'd0);
        idle_inputs();

        // Flush in the cycle after acceptance blocks the following request.
        memValid = 1'b1; memAddr = 5'd6; memData = 32'd77;
        flush = 1'b1;
        #1;
        check_value("flush_memready", 64'(memReady), 64'd0);
        step();
        check_value("flush_we", 64'(RegWriteControl), 64'd0);
        check_value("flush_addr_hold", 64'(RegWriteAddr), 64'd4);
        // Stall and flush together.
        stall = 1'b1;
        #1;
        check_value("sf_memready", 64'(memReady), 64'd0);
        step();
        check_value("sf_we", 64'(RegWriteControl), 64'd0);
        idle_inputs();
        step();
        check_value("rf_x6", 64'(rf[6]), 64'd0);
        check_value("rf_x4", 64'(rf[4]), 64'h55);

        // Asynchronous reset while the write enable is high.
        aluValid = 1'b1; aluAddr = 5'd7; aluData = 32'd99;
        step();
        idle_inputs();
        check_value("arst_pre_we", 64'(RegWriteControl), 64'd1);
        #1 reset = 1'b0;
        #1;
        check_value("arst_we", 64'(RegWriteControl), 64'd0);
        check_value("arst_addr", 64'(RegWriteAddr), 64'd0);
        check_value("arst_data", 64'(RegDataIn), 64'd0);
        step();
        #2 reset = 1'b1;
        step();
        check_value("arst_last", 64'(lastGrant), 64'd1);
        check_value("rf_x7", 64'(rf[7]), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
